// File: rtl/demux_sched_pkg.sv
// ----------------------------------------------------------------------------
// demux_sched_pkg
// Shared types and defaults for the demux scheduler.
//   state_e      : buffer state (EMPTY / FULL)
//   *_DEF        : default lane count, data width and stall timeout
//   onehot()     : lane index -> one-hot lane vector (up to MAX_LANES lanes)
// ----------------------------------------------------------------------------
package demux_sched_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam int N_OUT_DEF   = 8;
    localparam int DW_DEF      = 8;
    localparam int TIMEOUT_DEF = 15;
    localparam int MAX_LANES   = 16;
    localparam int IDXW        = 4;

    // Callers truncate the result to their own lane count.
    function automatic logic [MAX_LANES-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [MAX_LANES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_sched_if.sv
// ----------------------------------------------------------------------------
// demux_sched_if
// Bundles the scheduler's input handshake and lane-side signals.
//   mode, in_valid, in_data, in_dest : upstream word + routing request
//   in_ready                         : buffer can take a word this cycle
//   sel, out_data, out_valid         : demux select, held word, one-hot valid
//   out_ready                        : per-lane ready
//   drop                             : one-cycle discard pulse
//   rr_ptr                           : next round-robin lane
// modport slave  : the scheduler side
// modport master : the upstream/lane side (testbench or surrounding logic)
// ----------------------------------------------------------------------------
interface demux_sched_if #(
    parameter int N_OUT = demux_sched_pkg::N_OUT_DEF,
    parameter int DW    = demux_sched_pkg::DW_DEF,
    parameter int SELW  = $clog2(N_OUT)
);
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic [SELW-1:0]  in_dest;
    logic [SELW-1:0]  sel;
    logic [DW-1:0]    out_data;
    logic [N_OUT-1:0] out_valid;
    logic [N_OUT-1:0] out_ready;
    logic             drop;
    logic [SELW-1:0]  rr_ptr;

    modport slave (
        input  mode, in_valid, in_data, in_dest, out_ready,
        output in_ready, sel, out_data, out_valid, drop, rr_ptr
    );

    modport master (
        output mode, in_valid, in_data, in_dest, out_ready,
        input  in_ready, sel, out_data, out_valid, drop, rr_ptr
    );
endinterface

// File: rtl/demux_sched_timer.sv
// ----------------------------------------------------------------------------
// demux_sched_timer
// Tracks how long the held word has been stalled and produces the drop pulse.
//   clk, rst_n   : clock, asynchronous active-low reset
//   full_i       : a word is held
//   deliver_i    : held word is taken by its lane this cycle
//   load_i       : a new word is latched this cycle
//   bad_dest_i   : an incoming word was rejected for an out-of-range lane
//   timeout_o    : held word has waited TIMEOUT cycles and is discarded now
//   drop_o       : timeout discard (same cycle) or bad-dest reject (next cycle)
// ----------------------------------------------------------------------------
module demux_sched_timer
    import demux_sched_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic full_i,
    input  logic deliver_i,
    input  logic load_i,
    input  logic bad_dest_i,
    output logic timeout_o,
    output logic drop_o
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          bad_q;

    // Saturating so a TIMEOUT=0 build never wraps.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (load_i) begin
            wait_cnt_d = '0;
        end else if (full_i && !deliver_i && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            bad_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            bad_q      <= bad_dest_i;
        end
    end

    // A delivery in the expiry cycle wins over the timeout.
    assign timeout_o = (TIMEOUT != 0) && full_i && !deliver_i
                       && (int'(wait_cnt_q) == TIMEOUT);
    assign drop_o    = timeout_o || bad_q;

endmodule

// File: rtl/demux_sched.sv
// ----------------------------------------------------------------------------
// demux_sched
// Sequences a 1-to-N_OUT demux through a one-entry holding buffer. Each word
// goes to in_dest (mode 0) or the round-robin lane (mode 1); a word stalled
// for TIMEOUT cycles is discarded with a drop pulse.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : demux_sched_if.slave (handshake, lane signals, drop, rr_ptr)
//   stall_cnt_o : (only with DEMUX_SCHED_STALL_CNT_EN) saturating count of
//                 FULL cycles without delivery, cleared only by reset
// Optional feature macro: DEMUX_SCHED_STALL_CNT_EN
// ----------------------------------------------------------------------------
module demux_sched
    import demux_sched_pkg::*;
#(
    parameter int N_OUT   = N_OUT_DEF,
    parameter int DW      = DW_DEF,
    parameter int SELW    = $clog2(N_OUT),
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef DEMUX_SCHED_STALL_CNT_EN
    output logic [15:0]  stall_cnt_o,
`endif
    demux_sched_if.slave bus
);
    state_e          state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [SELW-1:0] rr_q, rr_d;
    logic            rr_word_q, rr_word_d;   // held word was routed round-robin

    logic            full, deliver, timeout, drop;
    logic            in_ready, accept, bad_dest, load, advance;
    logic [SELW-1:0] rr_eff, dest;

    assign full     = (state_q == FULL);
    assign deliver  = full && bus.out_ready[sel_q];
    assign in_ready = !full || deliver;
    assign accept   = bus.in_valid && in_ready;
    assign bad_dest = accept && !bus.mode && (int'(bus.in_dest) >= N_OUT);
    assign load     = accept && !bad_dest;

    // A word accepted in the same cycle the previous round-robin word leaves
    // must see the already-advanced pointer, otherwise back-to-back words
    // would land on the same lane twice.
    assign advance = rr_word_q && (deliver || timeout);
    assign rr_eff  = !advance ? rr_q
                   : (rr_q == SELW'(N_OUT - 1)) ? '0 : rr_q + 1'b1;
    assign dest    = bus.mode ? rr_eff : bus.in_dest;

    demux_sched_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .full_i    (full),
        .deliver_i (deliver),
        .load_i    (load),
        .bad_dest_i(bad_dest),
        .timeout_o (timeout),
        .drop_o    (drop)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        sel_d     = sel_q;
        rr_d      = rr_eff;
        rr_word_d = rr_word_q;
        if (load) begin
            state_d   = FULL;
            data_d    = bus.in_data;
            sel_d     = dest;
            rr_word_d = bus.mode;
        end else if (deliver || timeout) begin
            state_d   = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            data_q    <= '0;
            sel_q     <= '0;
            rr_q      <= '0;
            rr_word_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            rr_word_q <= rr_word_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.sel       = sel_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = full ? N_OUT'(onehot(IDXW'(sel_q))) : '0;
    assign bus.drop      = drop;
    assign bus.rr_ptr    = rr_q;

`ifdef DEMUX_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (full && !deliver && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_demux_sched.sv
// ----------------------------------------------------------------------------
// tb_demux_sched
// Self-checking bench for demux_sched: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// slot-level reference model (held word, its lane, its age, rr pointer).
// Optional feature macro: DEMUX_SCHED_STALL_CNT_EN
// ----------------------------------------------------------------------------
module tb_demux_sched;
    localparam int N_OUT   = 8;
    localparam int DW      = 8;
    localparam int SELW    = 3;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    demux_sched_if #(.N_OUT(N_OUT), .DW(DW), .SELW(SELW)) bus ();

`ifdef DEMUX_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    demux_sched #(.N_OUT(N_OUT), .DW(DW), .SELW(SELW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef DEMUX_SCHED_STALL_CNT_EN
        .stall_cnt_o(stall_cnt),
`endif
        .bus        (bus)
    );

    // Reference model: what is held, where it goes, how long it has waited.
    bit          m_full;
    logic [7:0]  m_data;
    int          m_lane;
    bit          m_rrw;
    int          m_age;
    int          m_rr;
    int          m_sel;
    logic [7:0]  m_odata;
    int          m_stall;
    int          act_log[$];   // lanes actually delivered by the DUT

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full  = 0;
        m_data  = '0;
        m_lane  = 0;
        m_rrw   = 0;
        m_age   = 0;
        m_rr    = 0;
        m_sel   = 0;
        m_odata = '0;
        m_stall = 0;
    endtask

    // One clock cycle: apply inputs after the falling edge, compare, advance model.
    task automatic drive(input bit md, input bit iv, input logic [7:0] d,
                         input int dst, input logic [7:0] ordy);
        bit dlv, tmo, exp_rdy;
        @(negedge clk);
        bus.mode      = md;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_dest   = dst[2:0];
        bus.out_ready = ordy;
        #1;
        dlv     = m_full && ordy[m_lane];
        tmo     = m_full && !dlv && (m_age == TIMEOUT);
        exp_rdy = !m_full || dlv;
        chk("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), m_full ? (32'd1 << m_lane) : 32'd0);
        chk("sel",       32'(bus.sel),       32'(m_sel));
        chk("out_data",  32'(bus.out_data),  32'(m_odata));
        chk("drop",      32'(bus.drop),      32'(tmo));
        chk("rr_ptr",    32'(bus.rr_ptr),    32'(m_rr));
`ifdef DEMUX_SCHED_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt),     32'(m_stall));
`endif
        if ((bus.out_valid & bus.out_ready) != '0) act_log.push_back(int'(bus.sel));

        if (m_full && !dlv && m_stall < 65535) m_stall++;
        if ((dlv || tmo) && m_rrw) m_rr = (m_rr + 1) % N_OUT;
        if (iv && exp_rdy) begin
            m_lane  = md ? m_rr : dst;
            m_data  = d;
            m_full  = 1;
            m_age   = 0;
            m_rrw   = md;
            m_sel   = m_lane;
            m_odata = d;
        end else if (dlv || tmo) begin
            m_full = 0;
        end else if (m_full) begin
            m_age++;
        end
    endtask

    initial begin
        int first_drop;
        int drops;
        int probs[5];
        int pr;
        bit md;
        logic [7:0] ordy;

        probs = '{0, 15, 50, 90, 100};
        rst_n         = 1'b0;
        bus.mode      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_dest   = '0;
        bus.out_ready = '0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sel",       32'(bus.sel),       32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_drop",      32'(bus.drop),      32'd0);
        chk("rst_rr_ptr",    32'(bus.rr_ptr),    32'd0);
        #2 rst_n = 1'b1;

        // Explicit destination, lane 5
        drive(0, 1, 8'hA5, 5, 8'hFF);
        drive(0, 0, 8'h00, 0, 8'hFF);
        chk("d5_out_valid", 32'(bus.out_valid), 32'h20);
        chk("d5_sel",       32'(bus.sel),       32'd5);
        chk("d5_out_data",  32'(bus.out_data),  32'hA5);
        chk("d5_in_ready",  32'(bus.in_ready),  32'd1);
        drive(0, 0, 8'h00, 0, 8'hFF);
        chk("d5_after",     32'(bus.out_valid), 32'd0);

        // Round-robin, 9 back-to-back words
        act_log.delete();
        for (int i = 0; i < 9; i++) begin
            drive(1, 1, 8'(i), 0, 8'hFF);
            chk("rr_in_ready", 32'(bus.in_ready), 32'd1);
        end
        drive(1, 0, 8'h00, 0, 8'hFF);
        chk("rr_count", 32'(act_log.size()), 32'd9);
        for (int i = 0; i < 9; i++)
            chk("rr_lane", (i < act_log.size()) ? 32'(act_log[i]) : 32'hFFFF_FFFF, 32'(i % 8));
        drive(1, 0, 8'h00, 0, 8'hFF);
        chk("rr_end_ptr", 32'(bus.rr_ptr), 32'd1);

        // Timeout on lane 2
        drive(0, 1, 8'h3C, 2, 8'h00);
        first_drop = 0;
        drops = 0;
        for (int k = 1; k <= 20; k++) begin
            drive(0, 0, 8'h00, 0, 8'h00);
            if (bus.drop) begin
                drops++;
                if (first_drop == 0) first_drop = k;
            end
            if (k == 17) chk("to_after_valid", 32'(bus.out_valid), 32'd0);
        end
        chk("to_first_drop", 32'(first_drop), 32'd16);
        chk("to_drop_count", 32'(drops), 32'd1);
        chk("to_rr_kept",    32'(bus.rr_ptr), 32'd1);

        // Lane 2 becomes ready on the 15th stalled cycle: delivered, no drop
        act_log.delete();
        drive(0, 1, 8'h5A, 2, 8'h00);
        drops = 0;
        for (int k = 1; k <= 15; k++) begin
            drive(0, 0, 8'h00, 0, (k == 15) ? 8'h04 : 8'h00);
            if (bus.drop) drops++;
        end
        drive(0, 0, 8'h00, 0, 8'h00);
        chk("late_drop_count", 32'(drops), 32'd0);
        chk("late_after_valid", 32'(bus.out_valid), 32'd0);
        chk("late_delivered", 32'(act_log.size()), 32'd1);

        // Lane 3 blocked by out_ready=F7, then released with a new word waiting
        drive(0, 1, 8'h77, 3, 8'hF7);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 8'h00, 0, 8'hF7);
            chk("blk_in_ready", 32'(bus.in_ready), 32'd0);
            chk("blk_valid",    32'(bus.out_valid), 32'h08);
        end
        drive(0, 1, 8'h88, 6, 8'hFF);
        chk("blk_accept_ready", 32'(bus.in_ready), 32'd1);
        drive(0, 0, 8'h00, 0, 8'hFF);
        chk("blk_new_valid", 32'(bus.out_valid), 32'h40);
        chk("blk_new_data",  32'(bus.out_data),  32'h88);

        // Asynchronous reset while a round-robin word is held on lane 1
        drive(1, 1, 8'h11, 0, 8'h00);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 8'h00;
        #1;
        chk("ar_pre_valid", 32'(bus.out_valid), 32'h02);
        chk("ar_pre_rr",    32'(bus.rr_ptr),    32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_valid",    32'(bus.out_valid), 32'd0);
        chk("ar_rr",       32'(bus.rr_ptr),    32'd0);
        chk("ar_drop",     32'(bus.drop),      32'd0);
        chk("ar_in_ready", 32'(bus.in_ready),  32'd1);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;

`ifdef DEMUX_SCHED_STALL_CNT_EN
        drive(0, 1, 8'h44, 4, 8'h00);
        for (int k = 0; k < 4; k++) drive(0, 0, 8'h00, 0, 8'h00);
        drive(0, 0, 8'h00, 0, 8'hFF);
        drive(0, 0, 8'h00, 0, 8'hFF);
        chk("stall_cnt_4", 32'(stall_cnt), 32'd4);
`endif

        // Randomized traffic against the model
        md = 1'b0;
        pr = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) pr = probs[$urandom_range(0, 4)];
            if ($urandom_range(0, 99) < 5) md = ~md;
            for (int b = 0; b < N_OUT; b++) ordy[b] = ($urandom_range(0, 99) < pr);
            drive(md, ($urandom_range(0, 99) < 70), 8'($urandom), int'($urandom_range(0, N_OUT - 1)), ordy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
